shift_engine: RTL and testbench
===============================

SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter DATA_W, default 8, frame data width in bits; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-003 Parameter ACK_EN, default 1; 1 = one acknowledge bit slot follows the data bits, 0 = no ack slot.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  frame request; accepted only in IDLE.
REQ-007 abort  input  1  terminates any frame; highest priority after rst.
REQ-008 rw_en  input  1  0 = write (parallel-to-serial), 1 = read (serial-to-parallel); sampled only when start is accepted.
REQ-009 bit_tick  input  1  shift strobe; one bit advances per cycle with bit_tick=1.
REQ-010 parallel_in  input  DATA_W  write data; captured when start is accepted.
REQ-011 sda_in  input  1  serial data in; also carries the ack in write frames.
REQ-012 ack_out  input  1  value driven during the read-frame ack slot.
REQ-013 parallel_out  output  DATA_W  last completed read-frame data.
REQ-014 sda_out  output  1  serial data out; 1 = released.
REQ-015 busy  output  1  high in SHIFT, ACK and DONE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 ack_rcvd  output  1  sda_in value sampled in the last write-frame ack slot; 0 = ACK.

Function
REQ-018 FSM states SHALL be IDLE, SHIFT, ACK, DONE.
REQ-019 IDLE, start=1: latch mode=rw_en; shift register <= parallel_in (write) or 0 (read); bit counter <= 0; next state SHIFT.
REQ-020 In SHIFT, write mode, sda_out SHALL present the current head bit: bit DATA_W-1 first if MSB_FIRST, else bit 0; first bit is visible the cycle after start is accepted.
REQ-021 In SHIFT, write mode, each bit_tick SHALL shift the register one position toward the head and increment the counter.
REQ-022 In SHIFT, read mode, each bit_tick SHALL shift sda_in in: MSB_FIRST inserts at bit 0 shifting left; LSB-first inserts at bit DATA_W-1 shifting right; sda_out=1.
REQ-023 A bit_tick with counter = DATA_W-1 SHALL move the FSM to ACK if ACK_EN=1, else to DONE; the counter SHALL NOT wrap within a frame.
REQ-024 In ACK, write mode: sda_out=1; on bit_tick, ack_rcvd <= sda_in and the FSM moves to DONE.
REQ-025 In ACK, read mode: sda_out=ack_out; on bit_tick the FSM moves to DONE.
REQ-026 In DONE: done=1 for exactly one cycle; read mode parallel_out <= shift register; write mode parallel_out unchanged; next state IDLE unconditionally.
REQ-027 Without bit_tick, SHIFT and ACK SHALL hold all state.
REQ-028 With bit_tick held high, a frame SHALL last DATA_W + ACK_EN + 1 cycles from the first SHIFT cycle through DONE.
REQ-029 start while busy=1 SHALL be ignored, and rw_en/parallel_in changes mid-frame SHALL have no effect.
REQ-030 abort=1 in any state SHALL return the FSM to IDLE next cycle: no done, parallel_out and ack_rcvd unchanged, sda_out=1.
REQ-031 abort and start together in IDLE: abort wins, start dropped.
REQ-032 In IDLE, sda_out=1 and busy=0.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, counter 0, shift register 0, parallel_out 0, sda_out 1, busy 0, done 0, ack_rcvd 1.
REQ-034 rst mid-frame SHALL discard the frame with no done pulse; the first start after rst release SHALL be accepted normally.

Verification
REQ-035 Defaults, write 0xAB, bit_tick=1, sda_in=0 in ack slot -> sda_out 1,0,1,0,1,0,1,1, then 1; ack_rcvd=0; done pulses 10 cycles after start.
REQ-036 Defaults, read, sda_in 1,0,1,0,1,1,0,0, ack_out=0 -> sda_out=0 in ack slot; parallel_out=0xAC with done.
REQ-037 DATA_W=16, MSB_FIRST=0, ACK_EN=0, write 0x8001, bit_tick every 3rd cycle -> sda_out 1, fourteen 0s, then 1; done after 16th tick; no ack slot.
REQ-038 Read frame, abort after 4 ticks -> IDLE next cycle; no done; parallel_out keeps 0xAC; next start runs a full frame.
REQ-039 start pulsed mid-frame with rw_en flipped -> ignored; frame completes in original mode.
REQ-040 rst asserted mid-write -> all outputs at reset values the same cycle; ack_rcvd=1; no done.

Source files
------------

// File: rtl/shift_engine.sv
// shift_engine: framed serial shifter with an optional acknowledge slot.
// Write frames serialise a captured word onto sda_out_o. Read frames deserialise
// sda_in_i into parallel_out_o. Every output is a flop. Each output is loaded
// from the next-state values, so it changes on the same edge as the FSM state.
module shift_engine #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned ACK_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              rw_en_i,
    input  logic              bit_tick_i,
    input  logic [DATA_W-1:0] parallel_in_i,
    input  logic              sda_in_i,
    input  logic              ack_out_i,
    output logic [DATA_W-1:0] parallel_out_o,
    output logic              sda_out_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ack_rcvd_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ACK   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                mode_q, mode_d;      // 1 = read frame
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   pout_q, pout_d;
    logic                ack_rcvd_q, ack_rcvd_d;
    logic                sda_q, sda_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // State and output registers; the reset values are the idle line levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            pout_q     <= '0;
            ack_rcvd_q <= 1'b1;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            pout_q     <= pout_d;
            ack_rcvd_q <= ack_rcvd_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic. The outputs are derived from the state being entered
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        pout_d     = pout_q;
        ack_rcvd_d = ack_rcvd_q;
        sda_d      = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_d  = rw_en_i;
                        shreg_d = rw_en_i ? '0 : parallel_in_i;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_tick_i) begin
                        if (MSB_FIRST != 0) begin
                            shreg_d = {shreg_q[DATA_W-2:0], mode_q & sda_in_i};
                        end else begin
                            shreg_d = {mode_q & sda_in_i, shreg_q[DATA_W-1:1]};
                        end
                        if (cnt_q == LAST_CNT) begin
                            state_d = (ACK_EN != 0) ? S_ACK : S_DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_ACK: begin
                    if (bit_tick_i) begin
                        if (!mode_q) begin
                            ack_rcvd_d = sda_in_i;
                        end
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Read data becomes visible in the same cycle as the done pulse
        if (state_d == S_DONE && state_q != S_DONE && mode_d) begin
            pout_d = shreg_d;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        unique case (state_d)
            S_SHIFT: sda_d = mode_d ? 1'b1
                           : ((MSB_FIRST != 0) ? shreg_d[DATA_W-1] : shreg_d[0]);
            S_ACK:   sda_d = mode_d ? ack_out_i : 1'b1;
            default: sda_d = 1'b1;
        endcase
    end

    assign parallel_out_o = pout_q;
    assign sda_out_o      = sda_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign ack_rcvd_o     = ack_rcvd_q;

endmodule

// File: tb/tb_shift_engine.sv
// Bench for shift_engine: a default instance (8-bit, MSB first, ack slot) and
// a 16-bit LSB-first instance with no ack slot, both checked against serial-order models.
module tb_shift_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic       a_start = 0, a_abort = 0, a_rw = 0, a_tick = 0, a_sda_in = 0, a_ackout = 0;
    logic [7:0] a_pin = '0;
    logic [7:0] a_pout;
    logic       a_sda, a_busy, a_done, a_ackr;

    // 16-bit LSB-first instance without ack slot
    logic        b_start = 0, b_abort = 0, b_rw = 0, b_tick = 0, b_sda_in = 0, b_ackout = 0;
    logic [15:0] b_pin = '0;
    logic [15:0] b_pout;
    logic        b_sda, b_busy, b_done, b_ackr;

    shift_engine u_a (
        .clk(clk), .rst(rst), .start_i(a_start), .abort_i(a_abort), .rw_en_i(a_rw),
        .bit_tick_i(a_tick), .parallel_in_i(a_pin), .sda_in_i(a_sda_in), .ack_out_i(a_ackout),
        .parallel_out_o(a_pout), .sda_out_o(a_sda), .busy_o(a_busy), .done_o(a_done),
        .ack_rcvd_o(a_ackr)
    );

    shift_engine #(.DATA_W(16), .MSB_FIRST(0), .ACK_EN(0)) u_b (
        .clk(clk), .rst(rst), .start_i(b_start), .abort_i(b_abort), .rw_en_i(b_rw),
        .bit_tick_i(b_tick), .parallel_in_i(b_pin), .sda_in_i(b_sda_in), .ack_out_i(b_ackout),
        .parallel_out_o(b_pout), .sda_out_o(b_sda), .busy_o(b_busy), .done_o(b_done),
        .ack_rcvd_o(b_ackr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference state for the default instance
    logic [7:0] m_pout = '0;
    logic       m_ackr = 1'b1;

    // observations collected by frame_a
    logic [7:0] f_sent;        // serial bits in transmit order, first bit at [7]
    logic       f_ack_slot;
    bit         f_done_seen;
    int         f_done_cyc, f_last_tick;
    logic [7:0] f_pout;
    logic       f_ackr, f_busy_after, f_done_after;

    // Serial order of a transmitted word: first bit ends up at position w-1
    function automatic logic [15:0] model_tx(input logic [15:0] d, input int w, input bit msb);
        logic [15:0] s = '0;
        for (int i = 0; i < w; i++) s[w-1-i] = msb ? d[w-1-i] : d[i];
        return s;
    endfunction

    // Parallel word assembled from serial bits (first bit held at position w-1)
    function automatic logic [15:0] model_rx(input logic [15:0] s, input int w, input bit msb);
        logic [15:0] d = '0;
        for (int i = 0; i < w; i++) begin
            if (msb) d[w-1-i] = s[w-1-i];
            else     d[i]     = s[w-1-i];
        end
        return d;
    endfunction

    // Drive one frame on the default instance and record what the line did
    task automatic frame_a(input logic rw, input logic [7:0] wdata, input logic [7:0] rseq,
                           input logic ackin, input logic ackout, input int tick_pct,
                           input bit glitch);
        int ticks = 0;
        int cyc = 0;
        bit tk;
        f_sent = '0; f_ack_slot = 1'bx; f_done_seen = 0; f_done_cyc = -1; f_last_tick = -2;
        @(posedge clk); #1;
        a_start = 1; a_rw = rw; a_pin = wdata; a_tick = 0; a_ackout = ackout;
        @(posedge clk); #1;
        a_start = 0; a_rw = ~rw; a_pin = 8'($urandom);
        cyc = 1;
        while (!f_done_seen && cyc < 400) begin
            if (a_done) begin
                f_done_seen = 1; f_done_cyc = cyc; f_pout = a_pout; f_ackr = a_ackr;
            end else begin
                tk = (ticks < 9) && (int'($urandom_range(99)) < tick_pct);
                a_tick  = tk;
                a_start = glitch && (ticks == 3);
                if (tk) begin
                    if (ticks < 8) begin
                        f_sent   = {f_sent[6:0], a_sda};
                        a_sda_in = rseq[7-ticks];
                    end else begin
                        f_ack_slot = a_sda;
                        a_sda_in   = ackin;
                    end
                    ticks++;
                    f_last_tick = cyc;
                end else begin
                    a_sda_in = 1'($urandom);
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        a_tick = 0; a_start = 0;
        @(posedge clk); #1;
        f_busy_after = a_busy; f_done_after = a_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (a_sda !== 1'b1) $display("FAIL reset_sda_a got=%b exp=1", a_sda); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy_a got=%b exp=0", a_busy); else n_pass++;
        n_checks++; if (a_done !== 1'b0) $display("FAIL reset_done_a got=%b exp=0", a_done); else n_pass++;
        n_checks++; if (a_ackr !== 1'b1) $display("FAIL reset_ackr_a got=%b exp=1", a_ackr); else n_pass++;
        n_checks++; if (a_pout !== 8'h00) $display("FAIL reset_pout_a got=%h exp=00", a_pout); else n_pass++;
        n_checks++; if (b_pout !== 16'h0000 || b_sda !== 1'b1 || b_busy !== 1'b0)
            $display("FAIL reset_b got pout=%h sda=%b busy=%b exp 0000/1/0", b_pout, b_sda, b_busy); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_ab();
        frame_a(1'b0, 8'hAB, 8'h00, 1'b0, 1'b0, 100, 1'b0);
        n_checks++; if (f_sent !== 8'b1010_1011) $display("FAIL wr_ab_bits got=%b exp=10101011", f_sent); else n_pass++;
        n_checks++; if (f_ack_slot !== 1'b1) $display("FAIL wr_ab_ackslot got=%b exp=1", f_ack_slot); else n_pass++;
        n_checks++; if (f_done_cyc !== 10) $display("FAIL wr_ab_latency got=%0d exp=10", f_done_cyc); else n_pass++;
        n_checks++; if (f_ackr !== 1'b0) $display("FAIL wr_ab_ackrcvd got=%b exp=0", f_ackr); else n_pass++;
        n_checks++; if (f_pout !== 8'h00) $display("FAIL wr_ab_pout got=%h exp=00", f_pout); else n_pass++;
        n_checks++; if (f_busy_after !== 1'b0 || f_done_after !== 1'b0)
            $display("FAIL wr_ab_idle got busy=%b done=%b exp 0/0", f_busy_after, f_done_after); else n_pass++;
        m_ackr = 1'b0;
    endtask

    task automatic test_read_ac();
        frame_a(1'b1, 8'h00, 8'b1010_1100, 1'b1, 1'b0, 100, 1'b0);
        n_checks++; if (f_sent !== 8'hFF) $display("FAIL rd_ac_line got=%b exp=11111111", f_sent); else n_pass++;
        n_checks++; if (f_ack_slot !== 1'b0) $display("FAIL rd_ac_ackslot got=%b exp=0", f_ack_slot); else n_pass++;
        n_checks++; if (f_pout !== 8'hAC) $display("FAIL rd_ac_pout got=%h exp=ac", f_pout); else n_pass++;
        n_checks++; if (f_done_cyc !== 10) $display("FAIL rd_ac_latency got=%0d exp=10", f_done_cyc); else n_pass++;
        n_checks++; if (f_ackr !== 1'b0) $display("FAIL rd_ac_ackrcvd got=%b exp=0", f_ackr); else n_pass++;
        m_pout = 8'hAC;
    endtask

    task automatic test_abort();
        int dones = 0;
        @(posedge clk); #1;
        a_start = 1; a_rw = 1; a_pin = 8'($urandom); a_tick = 0;
        @(posedge clk); #1;
        a_start = 0; a_tick = 1;
        repeat (4) begin a_sda_in = 1'($urandom); @(posedge clk); #1; end
        a_tick = 0;
        n_checks++; if (a_busy !== 1'b1) $display("FAIL abort_pre_busy got=%b exp=1", a_busy); else n_pass++;
        a_abort = 1;
        @(posedge clk); #1;
        a_abort = 0;
        n_checks++; if (a_busy !== 1'b0 || a_sda !== 1'b1)
            $display("FAIL abort_idle got busy=%b sda=%b exp 0/1", a_busy, a_sda); else n_pass++;
        n_checks++; if (a_pout !== m_pout) $display("FAIL abort_pout got=%h exp=%h", a_pout, m_pout); else n_pass++;
        a_tick = 1;
        repeat (12) begin if (a_done) dones++; @(posedge clk); #1; end
        a_tick = 0;
        n_checks++; if (dones !== 0) $display("FAIL abort_no_done got=%0d exp=0", dones); else n_pass++;
        // abort beats a simultaneous start
        a_abort = 1; a_start = 1; a_rw = 0;
        @(posedge clk); #1;
        a_abort = 0; a_start = 0;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL abort_vs_start got=%b exp=0", a_busy); else n_pass++;
        frame_a(1'b1, 8'h00, 8'h3C, 1'b0, 1'b1, 100, 1'b0);
        m_pout = 8'(model_rx(16'(8'h3C), 8, 1'b1));
        n_checks++; if (f_pout !== m_pout || f_done_cyc !== 10)
            $display("FAIL abort_next_frame got pout=%h lat=%0d exp %h/10", f_pout, f_done_cyc, m_pout); else n_pass++;
    endtask

    task automatic test_start_ignored();
        logic [7:0] d = 8'($urandom);
        logic ai = 1'($urandom);
        frame_a(1'b0, d, 8'h00, ai, 1'b0, 70, 1'b1);
        m_ackr = ai;
        n_checks++; if (f_sent !== 8'(model_tx(16'(d), 8, 1'b1)))
            $display("FAIL glitch_wr_bits got=%b exp=%b", f_sent, 8'(model_tx(16'(d), 8, 1'b1))); else n_pass++;
        n_checks++; if (f_ackr !== m_ackr || f_pout !== m_pout)
            $display("FAIL glitch_wr_state got ackr=%b pout=%h exp %b/%h", f_ackr, f_pout, m_ackr, m_pout); else n_pass++;
        d = 8'($urandom);
        frame_a(1'b1, 8'h00, d, 1'b1, 1'b1, 70, 1'b1);
        m_pout = 8'(model_rx(16'(d), 8, 1'b1));
        n_checks++; if (f_pout !== m_pout || f_sent !== 8'hFF)
            $display("FAIL glitch_rd got pout=%h line=%b exp %h/11111111", f_pout, f_sent, m_pout); else n_pass++;
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 20; k++) begin
            logic       rw = 1'($urandom);
            logic [7:0] d  = 8'($urandom);
            logic [7:0] s  = 8'($urandom);
            logic       ai = 1'($urandom);
            logic       ao = 1'($urandom);
            logic [7:0] exp_sent;
            frame_a(rw, d, s, ai, ao, int'($urandom_range(30, 100)), 1'b0);
            if (rw) begin
                m_pout = 8'(model_rx(16'(s), 8, 1'b1));
                exp_sent = 8'hFF;
            end else begin
                m_ackr = ai;
                exp_sent = 8'(model_tx(16'(d), 8, 1'b1));
            end
            n_checks++; if (!f_done_seen) $display("FAIL rnd%0d_timeout no done seen", k); else n_pass++;
            n_checks++; if (f_sent !== exp_sent) $display("FAIL rnd%0d_line got=%b exp=%b", k, f_sent, exp_sent); else n_pass++;
            n_checks++; if (f_ack_slot !== (rw ? ao : 1'b1))
                $display("FAIL rnd%0d_ackslot got=%b exp=%b", k, f_ack_slot, rw ? ao : 1'b1); else n_pass++;
            n_checks++; if (f_done_cyc !== f_last_tick + 1)
                $display("FAIL rnd%0d_done_timing got=%0d exp=%0d", k, f_done_cyc, f_last_tick + 1); else n_pass++;
            n_checks++; if (f_pout !== m_pout || f_ackr !== m_ackr)
                $display("FAIL rnd%0d_state got pout=%h ackr=%b exp %h/%b", k, f_pout, f_ackr, m_pout, m_ackr); else n_pass++;
            n_checks++; if (f_busy_after !== 1'b0) $display("FAIL rnd%0d_idle got busy=%b exp=0", k, f_busy_after); else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        int dones = 0;
        frame_a(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 100, 1'b0);
        m_ackr = 1'b0;
        @(posedge clk); #1;
        a_start = 1; a_rw = 0; a_pin = 8'h00;
        @(posedge clk); #1;
        a_start = 0; a_tick = 1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (a_busy !== 1'b1 || a_sda !== 1'b0)
            $display("FAIL rst_mid_pre got busy=%b sda=%b exp 1/0", a_busy, a_sda); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (a_sda !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0)
            $display("FAIL rst_mid_lines got sda=%b busy=%b done=%b exp 1/0/0", a_sda, a_busy, a_done); else n_pass++;
        n_checks++; if (a_ackr !== 1'b1 || a_pout !== 8'h00)
            $display("FAIL rst_mid_regs got ackr=%b pout=%h exp 1/00", a_ackr, a_pout); else n_pass++;
        m_ackr = 1'b1; m_pout = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) begin if (a_done) dones++; @(posedge clk); #1; end
        a_tick = 0;
        n_checks++; if (dones !== 0) $display("FAIL rst_mid_no_done got=%0d exp=0", dones); else n_pass++;
        frame_a(1'b0, 8'h96, 8'h00, 1'b0, 1'b0, 100, 1'b0);
        m_ackr = 1'b0;
        n_checks++; if (f_sent !== 8'h96 || f_done_cyc !== 10 || f_ackr !== m_ackr)
            $display("FAIL rst_mid_next got bits=%h lat=%0d ackr=%b exp 96/10/0", f_sent, f_done_cyc, f_ackr); else n_pass++;
    endtask

    task automatic test_lsb16();
        logic [15:0] m_pout_b = '0;
        for (int f = 0; f < 4; f++) begin
            logic        rw  = (f == 0) ? 1'b0 : 1'($urandom);
            logic [15:0] d   = (f == 0) ? 16'h8001 : 16'($urandom);
            logic [15:0] s   = 16'($urandom);
            int          per = (f == 0) ? 3 : int'($urandom_range(1, 3));
            logic [15:0] sent = '0;
            logic [15:0] exp_sent;
            int ticks = 0, cyc = 1, done_cyc = -1, last_tick = -2;
            @(posedge clk); #1;
            b_start = 1; b_rw = rw; b_pin = d; b_tick = 0;
            @(posedge clk); #1;
            b_start = 0; b_rw = ~rw; b_pin = 16'($urandom);
            while (done_cyc < 0 && cyc < 400) begin
                if (b_done) begin
                    done_cyc = cyc;
                    if (rw) m_pout_b = model_rx(s, 16, 1'b0);
                    n_checks++; if (b_pout !== m_pout_b)
                        $display("FAIL b%0d_pout got=%h exp=%h", f, b_pout, m_pout_b); else n_pass++;
                end else begin
                    b_tick = (ticks < 16) && (cyc % per == 0);
                    if (b_tick) begin
                        sent = {sent[14:0], b_sda};
                        b_sda_in = s[15-ticks];
                        ticks++;
                        last_tick = cyc;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
            end
            b_tick = 0;
            exp_sent = rw ? 16'hFFFF : model_tx(d, 16, 1'b0);
            if (f == 0) begin
                n_checks++; if (sent !== 16'h8001) $display("FAIL b_8001_bits got=%b exp=1000000000000001", sent); else n_pass++;
            end
            n_checks++; if (sent !== exp_sent) $display("FAIL b%0d_line got=%h exp=%h", f, sent, exp_sent); else n_pass++;
            n_checks++; if (done_cyc !== last_tick + 1)
                $display("FAIL b%0d_done_timing got=%0d exp=%0d", f, done_cyc, last_tick + 1); else n_pass++;
            n_checks++; if (b_ackr !== 1'b1) $display("FAIL b%0d_ackrcvd got=%b exp=1", f, b_ackr); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (b_busy !== 1'b0 || b_done !== 1'b0)
                $display("FAIL b%0d_idle got busy=%b done=%b exp 0/0", f, b_busy, b_done); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_ab();
        test_read_ac();
        test_abort();
        test_start_ignored();
        test_random_frames();
        test_rst_mid();
        test_lsb16();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
